// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, status encodings, Rcon and the
// GF(2^8) column helpers used by the iterative core.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } aes_fsm_e;

    localparam logic [3:0] ROUND_IDLE = 4'd0;
    localparam logic [3:0] ROUND_LAST = 4'd10;
    localparam logic [3:0] ROUND_DONE = 4'd11;

    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_BUSY = 2'b01;
    localparam logic [1:0] RW_DONE = 2'b10;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are a0 (row 0, MSB) .. a3 (row 3); multiply by the circulant {2,3,1,1}.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

    // Row r of the column-major block rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        return {s[127:120], s[87:80],   s[47:40],   s[7:0],
                s[95:88],   s[55:48],   s[15:8],    s[103:96],
                s[63:56],   s[23:16],   s[111:104], s[71:64],
                s[31:24],   s[119:112], s[79:72],   s[39:32]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; the 256-entry table is packed into one
// constant with entry 0 in the most significant byte.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ~i_byte is (255 - i_byte), so entry 0 sits at the top of the table.
    assign o_byte = SBOX_TBL[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes128_iterative.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key
// expansion; debug ports expose the key, state, captured block and round.
module aes128_iterative
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en_aes,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic [127:0] test1,
    output logic [127:0] test2,
    output logic [127:0] test3,
    output logic [4:0]   test_state,
    output logic [1:0]   rw
);

    aes_fsm_e     r_fsm;
    logic [3:0]   r_round;
    logic [127:0] r_key;
    logic [127:0] r_state;
    logic [127:0] r_pt;
    logic [127:0] r_dout;
    logic [1:0]   r_rw;

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_round_out;
    logic [31:0]  w_rot;
    logic [31:0]  w_subword;
    logic [31:0]  w_temp;
    logic [127:0] w_next_key;

    for (genvar gi = 0; gi < 16; gi++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .i_byte (r_state[127-8*gi -: 8]),
            .o_byte (w_sb[127-8*gi -: 8])
        );
    end

    // SubWord on RotWord(w3) of the current round key.
    assign w_rot = {r_key[23:0], r_key[31:24]};
    for (genvar gk = 0; gk < 4; gk++) begin : g_sub_word
        aes_sbox u_sbox (
            .i_byte (w_rot[31-8*gk -: 8]),
            .o_byte (w_subword[31-8*gk -: 8])
        );
    end

    assign w_temp = w_subword ^ {rcon(r_round), 24'h000000};
    assign w_next_key[127:96] = r_key[127:96] ^ w_temp;
    assign w_next_key[95:64]  = r_key[95:64]  ^ w_next_key[127:96];
    assign w_next_key[63:32]  = r_key[63:32]  ^ w_next_key[95:64];
    assign w_next_key[31:0]   = r_key[31:0]   ^ w_next_key[63:32];

    assign w_sr = shift_rows(w_sb);
    assign w_mc = mix_columns(w_sr);

    // The final round omits MixColumns.
    always_comb begin
        w_round_out = 128'd0;
        if (r_round == ROUND_LAST) begin
            w_round_out = w_sr ^ w_next_key;
        end else begin
            w_round_out = w_mc ^ w_next_key;
        end
    end

    // Round sequencer, datapath registers and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fsm   <= S_IDLE;
            r_round <= ROUND_IDLE;
            r_key   <= 128'd0;
            r_state <= 128'd0;
            r_pt    <= 128'd0;
            r_dout  <= 128'd0;
            r_rw    <= RW_IDLE;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (en_aes) begin
                        r_state <= data_in ^ key_in;
                        r_key   <= key_in;
                        r_pt    <= data_in;
                        r_round <= 4'd1;
                        r_rw    <= RW_BUSY;
                        r_fsm   <= S_ROUND;
                    end else begin
                        r_round <= ROUND_IDLE;
                        r_rw    <= RW_IDLE;
                    end
                end
                S_ROUND: begin
                    r_key   <= w_next_key;
                    r_state <= w_round_out;
                    if (r_round == ROUND_LAST) begin
                        r_dout  <= w_round_out;
                        r_round <= ROUND_DONE;
                        r_rw    <= RW_DONE;
                        r_fsm   <= S_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_rw    <= RW_BUSY;
                    end
                end
                S_DONE: begin
                    r_round <= ROUND_IDLE;
                    r_rw    <= RW_IDLE;
                    r_fsm   <= S_IDLE;
                end
                default: begin
                    r_round <= ROUND_IDLE;
                    r_rw    <= RW_IDLE;
                    r_fsm   <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_dout;
    assign test1      = r_key;
    assign test2      = r_state;
    assign test3      = r_pt;
    assign test_state = {1'b0, r_round};
    assign rw         = r_rw;

endmodule

// File: tb/tb_aes128_iterative.sv
// Bench for aes128_iterative: an algebraic AES model (S-box from GF inverse
// plus affine map) predicts every output each cycle; FIPS vectors pin it.
module tb_aes128_iterative;

    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_PT2  = 128'h3243f6a8885a308d313198a2e0370735;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] B_ST1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en_aes = 1'b0;
    logic [127:0] data_in = 128'd0;
    logic [127:0] key_in = 128'd0;
    logic [127:0] data_out, test1, test2, test3;
    logic [4:0]   test_state;
    logic [1:0]   rw;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    logic [7:0]   sb_tab [256];
    logic [127:0] calc_rk [11];
    logic [127:0] calc_st [11];

    logic [127:0] m_rk [11];
    logic [127:0] m_st [11];
    logic [3:0]   m_phase = 4'd0;
    logic [127:0] m_key = 128'd0, m_state = 128'd0, m_pt = 128'd0, m_dout = 128'd0;

    aes128_iterative dut (
        .clk        (clk),
        .reset      (reset),
        .en_aes     (en_aes),
        .data_in    (data_in),
        .key_in     (key_in),
        .data_out   (data_out),
        .test1      (test1),
        .test2      (test2),
        .test3      (test3),
        .test_state (test_state),
        .rw         (rw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box by definition: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] mcoef(input int d);
        return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
    endfunction

    // Full key schedule and per-round state into calc_rk / calc_st.
    task automatic aes_sched(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [127:0] v;
        logic [127:0] pk;
        logic [7:0]   rc;
        logic [7:0]   acc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        rc = 8'h01;
        for (int i = 0; i < 4; i++) begin
            v = key >> (96 - 32 * i);
            w[i] = v[31:0];
        end
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]], sb_tab[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) calc_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int i = 0; i < 16; i++) begin
            v = (pt ^ key) >> (120 - 8 * i);
            s[i] = v[7:0];
        end
        calc_st[0] = pt ^ key;
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = sb_tab[s[row + 4*((c + row) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) begin
                    if (r < 10) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(mcoef((k - row + 4) % 4), t[k + 4*c]);
                        s[row + 4*c] = acc;
                    end else begin
                        s[row + 4*c] = t[row + 4*c];
                    end
                end
            pk = 128'd0;
            for (int i = 0; i < 16; i++) begin
                v = calc_rk[r] >> (120 - 8 * i);
                s[i] = s[i] ^ v[7:0];
                pk = {pk[119:0], s[i]};
            end
            calc_st[r] = pk;
        end
    endtask

    function automatic logic [1:0] exp_rw(input logic [3:0] ph);
        return (ph == 4'd0) ? 2'b00 : (ph == 4'd11) ? 2'b10 : 2'b01;
    endfunction

    // Reference model: phase 0 idle, 1..10 rounds pending, 11 done.
    always @(posedge clk) begin
        if (!reset) begin
            m_phase <= 4'd0;
            m_key   <= 128'd0;
            m_state <= 128'd0;
            m_pt    <= 128'd0;
            m_dout  <= 128'd0;
        end else if (m_phase == 4'd0) begin
            if (en_aes) begin
                aes_sched(data_in, key_in);
                for (int i = 0; i < 11; i++) begin
                    m_rk[i] <= calc_rk[i];
                    m_st[i] <= calc_st[i];
                end
                m_key   <= key_in;
                m_state <= data_in ^ key_in;
                m_pt    <= data_in;
                m_phase <= 4'd1;
            end
        end else if (m_phase <= 4'd10) begin
            m_key   <= m_rk[m_phase];
            m_state <= m_st[m_phase];
            if (m_phase == 4'd10) m_dout <= m_st[10];
            m_phase <= m_phase + 4'd1;
        end else begin
            m_phase <= 4'd0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_data_out", data_out, m_dout);
            chk("cyc_test1", test1, m_key);
            chk("cyc_test2", test2, m_state);
            chk("cyc_test3", test3, m_pt);
            chk("cyc_test_state", {123'd0, test_state}, {124'd0, m_phase});
            chk("cyc_rw", {126'd0, rw}, {126'd0, exp_rw(m_phase)});
        end
    end

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (rw !== 2'b10 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {126'd0, rw}, {126'd0, 2'b10});
    endtask

    task automatic start(input logic [127:0] pt, input logic [127:0] key);
        data_in = pt;
        key_in  = key;
        en_aes  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses;
        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

        aes_sched(B_PT, B_KEY);
        chk("model_b_ct", calc_st[10], B_CT);
        chk("model_b_rk1", calc_rk[1], B_RK1);
        chk("model_b_st1", calc_st[1], B_ST1);
        chk("model_b_rk10", calc_rk[10], B_RK10);
        aes_sched(C_PT, C_KEY);
        chk("model_c_ct", calc_st[10], C_CT);

        // Reset for one edge, then release with en_aes low.
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_data_out", data_out, 128'd0);
        chk("rst_test1", test1, 128'd0);
        chk("rst_test2", test2, 128'd0);
        chk("rst_test_state", {123'd0, test_state}, 128'd0);
        chk("rst_rw", {126'd0, rw}, 128'd0);

        // Appendix B vector with round-1 and round-10 probes.
        start(B_PT, B_KEY);
        en_aes = 1'b0;
        @(negedge clk);
        chk("b_rk1", test1, B_RK1);
        chk("b_st1", test2, B_ST1);
        wait_done(1, n);
        chk("b_latency", 128'(n), 128'd10);
        chk("b_ct", data_out, B_CT);
        chk("b_rk10", test1, B_RK10);
        chk("b_state_done", {123'd0, test_state}, 128'd11);
        @(negedge clk);
        chk("b_rw_idle", {126'd0, rw}, 128'd0);
        chk("b_ct_hold", data_out, B_CT);

        // Appendix C.1 vector; en_aes dropped mid-run, rw must pulse exactly once.
        start(C_PT, C_KEY);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) en_aes = 1'b0;
            if (rw == 2'b10) pulses++;
            @(negedge clk);
        end
        chk("c_pulses", 128'(pulses), 128'd1);
        chk("c_ct", data_out, C_CT);
        chk("c_rw_after", {126'd0, rw}, 128'd0);

        // Back-to-back with en_aes held; data_in changes mid-run.
        start(B_PT, B_KEY);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        data_in = B_PT2;
        wait_done(3, n);
        chk("bb_latency", 128'(n), 128'd10);
        chk("bb_ct_first", data_out, B_CT);
        @(negedge clk);
        chk("bb_idle_gap", {123'd0, test_state}, 128'd0);
        @(negedge clk);
        chk("bb_recapture", {123'd0, test_state}, 128'd1);
        chk("bb_test3", test3, B_PT2);
        en_aes = 1'b0;
        wait_done(0, n);
        chk("bb_latency2", 128'(n), 128'd10);
        aes_sched(B_PT2, B_KEY);
        chk("bb_ct_second", data_out, calc_st[10]);
        @(negedge clk);

        // Reset during round 5, then a clean restart.
        start(C_PT, C_KEY);
        en_aes = 1'b0;
        n = 0;
        while (test_state != 5'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("r5_reached", {123'd0, test_state}, 128'd5);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_rst_data_out", data_out, 128'd0);
        chk("mid_rst_test1", test1, 128'd0);
        chk("mid_rst_test2", test2, 128'd0);
        chk("mid_rst_test3", test3, 128'd0);
        chk("mid_rst_state", {123'd0, test_state}, 128'd0);
        chk("mid_rst_rw", {126'd0, rw}, 128'd0);
        start(C_PT, C_KEY);
        en_aes = 1'b0;
        wait_done(0, n);
        chk("restart_latency", 128'(n), 128'd10);
        chk("restart_ct", data_out, C_CT);
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
